// File: rtl/sync_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// sync_pkg : shared limits and helpers for the synchroniser family
// Rev 1.0
//------------------------------------------------------------------------------
package sync_pkg;

    localparam int SYNC_MIN_STAGES = 2;
    localparam int SYNC_MAX_STAGES = 4;
    localparam int SYNC_MAX_FILT   = 255;
    localparam int SYNC_MAX_WIDTH  = 64;

    // Bits needed to hold values 0..v-1, never less than 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_bank_filt_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// sync_bank_filt_if : async input vector and synchronised/filtered results
// Rev 1.0
//------------------------------------------------------------------------------
interface sync_bank_filt_if #(
    parameter int WIDTH  = 1,
    parameter int BCNT_W = 8
);
    logic [WIDTH-1:0]  d;
    logic              bounce_clr;
    logic [WIDTH-1:0]  q;
    logic [WIDTH-1:0]  q_rise;
    logic [WIDTH-1:0]  q_fall;
    logic              q_chg;
    logic              bounce;
    logic [BCNT_W-1:0] bounce_cnt;

    modport master (
        output d, bounce_clr,
        input  q, q_rise, q_fall, q_chg, bounce, bounce_cnt
    );

    modport slave (
        input  d, bounce_clr,
        output q, q_rise, q_fall, q_chg, bounce, bounce_cnt
    );
endinterface
`default_nettype wire

// File: rtl/sync_bit_chain.sv
`default_nettype none
//------------------------------------------------------------------------------
// sync_bit_chain : single-bit multi-flop synchroniser leaf
// Rev 1.0
//------------------------------------------------------------------------------
module sync_bit_chain #(
    parameter int STAGES  = 3,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic clr_,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            r_chain <= {STAGES{RST_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/sync_bank_filt.sv
`default_nettype none
//------------------------------------------------------------------------------
// sync_bank_filt : WIDTH-bit level synchroniser with optional debounce filter
// Rev 1.0
//------------------------------------------------------------------------------
module sync_bank_filt
    import sync_pkg::*;
#(
    parameter int               WIDTH    = 1,
    parameter int               STAGES   = 3,
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    parameter int               FILT_CNT = 0,
    parameter int               BCNT_W   = 8
) (
    input  logic                clk,
    input  logic                clr_,
    sync_bank_filt_if.slave     bus
);

    if (WIDTH < 1 || WIDTH > SYNC_MAX_WIDTH) begin : g_bad_width
        $error("sync_bank_filt: WIDTH must be 1..64");
    end
    if (STAGES < SYNC_MIN_STAGES || STAGES > SYNC_MAX_STAGES) begin : g_bad_stages
        $error("sync_bank_filt: STAGES must be 2..4");
    end
    if (FILT_CNT < 0 || FILT_CNT > SYNC_MAX_FILT) begin : g_bad_filt
        $error("sync_bank_filt: FILT_CNT must be 0..255");
    end

    logic [WIDTH-1:0]  w_s;
    logic [WIDTH-1:0]  w_q;
    logic              w_bounce_evt;
    logic              w_bounce;
    logic [WIDTH-1:0]  r_q_prev;
    logic [BCNT_W-1:0] r_bcnt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sync_bit_chain #(
            .STAGES  (STAGES),
            .RST_VAL (RST_VAL[i])
        ) u_chain (
            .clk  (clk),
            .clr_ (clr_),
            .d    (bus.d[i]),
            .q    (w_s[i])
        );
    end

    if (FILT_CNT == 0) begin : g_bypass
        assign w_q          = w_s;
        assign w_bounce_evt = 1'b0;
        assign w_bounce     = 1'b0;
    end else begin : g_filt
        localparam int RW = clog2(FILT_CNT + 1);
        localparam logic [RW-1:0] c_n = RW'(FILT_CNT);

        logic [WIDTH-1:0] r_s_prev;
        logic [RW-1:0]    r_run;
        logic [WIDTH-1:0] r_q;
        logic             r_bounce;
        logic             w_stable;
        logic             w_qual;

        // Any bit moving restarts qualification for the whole vector.
        assign w_stable     = (w_s == r_s_prev);
        assign w_qual       = w_stable &&
                              ((r_run == c_n - 1'b1) || ((r_run == c_n) && (w_s != r_q)));
        assign w_bounce_evt = !w_stable && (r_run < c_n) && (r_s_prev != r_q);

        always_ff @(posedge clk or negedge clr_) begin
            if (!clr_) begin
                r_s_prev <= RST_VAL;
                r_run    <= c_n;
                r_q      <= RST_VAL;
                r_bounce <= 1'b0;
            end else begin
                r_s_prev <= w_s;
                if (!w_stable) begin
                    r_run <= '0;
                end else if (r_run < c_n) begin
                    r_run <= r_run + 1'b1;
                end
                if (w_qual) begin
                    r_q <= w_s;
                end
                r_bounce <= w_bounce_evt;
            end
        end

        assign w_q      = r_q;
        assign w_bounce = r_bounce;
    end

    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            r_q_prev <= RST_VAL;
        end else begin
            r_q_prev <= w_q;
        end
    end

    // Clear wins over a coincident bounce event.
    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            r_bcnt <= '0;
        end else if (bus.bounce_clr) begin
            r_bcnt <= '0;
        end else if (w_bounce_evt && (r_bcnt != {BCNT_W{1'b1}})) begin
            r_bcnt <= r_bcnt + 1'b1;
        end
    end

    assign bus.q          = w_q;
    assign bus.q_rise     = w_q & ~r_q_prev;
    assign bus.q_fall     = ~w_q & r_q_prev;
    assign bus.q_chg      = |(w_q ^ r_q_prev);
    assign bus.bounce     = w_bounce;
    assign bus.bounce_cnt = r_bcnt;

endmodule
`default_nettype wire

// File: tb/tb_sync_bank_filt.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_sync_bank_filt : randomised bench with a history-based reference model
// Rev 1.0
//------------------------------------------------------------------------------
module tb_sync_bank_filt;

    logic clk;
    logic clr_;
    int   n_chk;
    int   n_err;

    // Reference model: h[id][0] is the newest d sample; s before an edge is h[id][STAGES-1].
    logic [63:0] h   [3][16];
    logic [63:0] mq  [3];
    logic [63:0] mqp [3];
    int          mcnt[3];
    logic        mb  [3];

    sync_bank_filt_if #(.WIDTH(4), .BCNT_W(8)) ifa ();
    sync_bank_filt_if #(.WIDTH(1), .BCNT_W(8)) ifb ();
    sync_bank_filt_if #(.WIDTH(8), .BCNT_W(8)) ifc ();

    sync_bank_filt #(.WIDTH(4), .STAGES(3), .RST_VAL(4'b1010), .FILT_CNT(0), .BCNT_W(8))
        u_dut_a (.clk(clk), .clr_(clr_), .bus(ifa));
    sync_bank_filt #(.WIDTH(1), .STAGES(2), .RST_VAL(1'b0), .FILT_CNT(0), .BCNT_W(8))
        u_dut_b (.clk(clk), .clr_(clr_), .bus(ifb));
    sync_bank_filt #(.WIDTH(8), .STAGES(3), .RST_VAL(8'h00), .FILT_CNT(4), .BCNT_W(8))
        u_dut_c (.clk(clk), .clr_(clr_), .bus(ifc));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk = n_chk + 1;
        if (obs !== exp_v) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic mreset(input int id, input logic [63:0] rv);
        for (int j = 0; j < 16; j++) h[id][j] = rv;
        mq[id]   = rv;
        mqp[id]  = rv;
        mcnt[id] = 0;
        mb[id]   = 1'b0;
    endtask

    // One clock edge: q follows s once s has shown the same value on n+1 consecutive edges.
    task automatic mstep(input int id, input int st, input int n,
                         input logic [63:0] dv, input logic bclr);
        logic [63:0] s, qn;
        logic        bn, same;
        int          run;
        s  = h[id][st-1];
        qn = mq[id];
        bn = 1'b0;
        if (n == 0) begin
            qn = h[id][st-2];
        end else begin
            same = 1'b1;
            for (int j = 0; j <= n; j++) if (h[id][st-1+j] != s) same = 1'b0;
            if (same) qn = s;
            run  = 0;
            same = 1'b1;
            for (int j = 0; j <= n; j++) begin
                if (same && h[id][st+j] == h[id][st]) run++;
                else same = 1'b0;
            end
            bn = (s != h[id][st]) && (run <= n) && (h[id][st] != mq[id]);
        end
        mqp[id] = mq[id];
        mq[id]  = qn;
        mb[id]  = bn;
        if (bclr) mcnt[id] = 0;
        else if (bn && mcnt[id] < 255) mcnt[id] = mcnt[id] + 1;
        for (int j = 15; j > 0; j--) h[id][j] = h[id][j-1];
        h[id][0] = dv;
    endtask

    task automatic cmp_dut(input string nm, input int id,
                           input logic [63:0] q, input logic [63:0] rise, input logic [63:0] fall,
                           input logic chg, input logic b, input logic [63:0] cnt);
        logic [63:0] er, ef;
        er = mq[id] & ~mqp[id];
        ef = ~mq[id] & mqp[id];
        chk({nm, ".q"},      q,             mq[id]);
        chk({nm, ".rise"},   rise,          er);
        chk({nm, ".fall"},   fall,          ef);
        chk({nm, ".chg"},    64'(chg),      64'(|(er | ef)));
        chk({nm, ".bounce"}, 64'(b),        64'(mb[id]));
        chk({nm, ".bcnt"},   cnt,           64'(mcnt[id]));
    endtask

    task automatic compare_all();
        cmp_dut("A", 0, 64'(ifa.q), 64'(ifa.q_rise), 64'(ifa.q_fall), ifa.q_chg, ifa.bounce, 64'(ifa.bounce_cnt));
        cmp_dut("B", 1, 64'(ifb.q), 64'(ifb.q_rise), 64'(ifb.q_fall), ifb.q_chg, ifb.bounce, 64'(ifb.bounce_cnt));
        cmp_dut("C", 2, 64'(ifc.q), 64'(ifc.q_rise), 64'(ifc.q_fall), ifc.q_chg, ifc.bounce, 64'(ifc.bounce_cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        if (clr_) begin
            mstep(0, 3, 0, 64'(ifa.d), ifa.bounce_clr);
            mstep(1, 2, 0, 64'(ifb.d), ifb.bounce_clr);
            mstep(2, 3, 4, 64'(ifc.d), ifc.bounce_clr);
        end
        #1;
        compare_all();
    endtask

    task automatic ticks(input int k);
        for (int j = 0; j < k; j++) tick();
    endtask

    // Asserted mid-cycle, so the asynchronous path is what clears the design.
    task automatic pulse_reset(input int cyc);
        clr_ = 1'b0;
        mreset(0, 64'h0a);
        mreset(1, 64'h0);
        mreset(2, 64'h0);
        #1;
        compare_all();
        ticks(cyc);
        clr_ = 1'b1;
    endtask

    task automatic set_bclr(input logic v);
        ifa.bounce_clr = v;
        ifb.bounce_clr = v;
        ifc.bounce_clr = v;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        clr_  = 1'b1;
        ifa.d = 4'b0101;
        ifb.d = 1'b0;
        ifc.d = 8'h00;
        set_bclr(1'b0);
        #1;
        pulse_reset(2);
        ticks(6);

        // Bypass latency on the 2-stage instance.
        ifb.d = 1'b1;
        ticks(4);

        // Multi-bit update, then a bit-0 toggle while qualifying.
        ifc.d = 8'hF0;
        ticks(10);
        ifc.d = 8'h00;
        ticks(10);
        ifc.d = 8'hF0;
        ticks(3);
        ifc.d = 8'hF1;
        tick();
        ifc.d = 8'hF0;
        ticks(12);
        ifc.d = 8'h00;
        ticks(10);

        // Reset in the middle of a pending qualification, input held through release.
        ifc.d = 8'h3C;
        ticks(5);
        pulse_reset(1);
        ticks(12);
        ifc.d = 8'h00;
        ticks(10);

        // Glitch train drives the bounce counter into saturation.
        for (int g = 0; g < 300; g++) begin
            ifc.d = 8'h01;
            ifb.d = ~ifb.d;
            tick();
            ifc.d = 8'h00;
            ticks(2);
        end
        chk("C.bcnt_sat", 64'(ifc.bounce_cnt), 64'd255);

        // Clear held across every bounce event keeps the count at zero.
        set_bclr(1'b1);
        for (int g = 0; g < 4; g++) begin
            ifc.d = 8'h01;
            tick();
            ifc.d = 8'h00;
            ticks(2);
        end
        set_bclr(1'b0);
        ticks(6);

        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(3) == 0) ifa.d = 4'($urandom);
            if ($urandom_range(2) == 0) ifb.d = 1'($urandom);
            if ($urandom_range(7) == 0) begin
                if ($urandom_range(1) == 0) ifc.d = 8'($urandom);
                else ifc.d = ifc.d ^ (8'h01 << $urandom_range(7));
            end
            set_bclr($urandom_range(15) == 0);
            if ($urandom_range(249) == 0) pulse_reset($urandom_range(2, 1));
            else tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
